// File: rtl/seq_divider_pkg.sv
// Shared types and latency constants for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    ITER = 2'd2,
    FIX  = 2'd3
  } state_t;

  localparam int DBZ_LATENCY = 2;

  // Edges from the start-sampling edge to the first cycle with done visible.
  function automatic int latency(input int width);
    return width + 2;
  endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Start/busy/done handshake and operand/result bus of the divider.
interface seq_divider_if #(parameter int WIDTH = 32);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, is_signed, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, is_signed, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider_step.sv
// One combinational restoring-division iteration: shift in a dividend bit, trial-subtract.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] div_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_o
);
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // One extra bit so the shifted remainder can never overflow.
    assign shifted = {rem_i, bit_i};
    assign diff    = shifted - {1'b0, div_i};
    assign q_o     = (shifted >= {1'b0, div_i});
    // Restored remainder is always below the divisor, so WIDTH bits suffice.
    assign rem_o   = q_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock, optional two's-complement mode.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic          clock,
    input  logic          reset_n,
    seq_divider_if.slave  bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q, r_q, quo_q, rem_q;
    logic [CW-1:0]    cnt_q;
    logic             sgn_q, qneg_q, rneg_q, zero_q;
    logic             busy_q, done_q, dbz_q;
    logic [WIDTH-1:0] r_d;
    logic             qbit;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i (r_q),
        .bit_i (a_q[WIDTH-1]),
        .div_i (b_q),
        .rem_o (r_d),
        .q_o   (qbit)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            sgn_q   <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            zero_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (bus.start) begin
                    a_q     <= bus.dividend;
                    b_q     <= bus.divisor;
                    sgn_q   <= bus.is_signed & SIGNED_EN;
                    busy_q  <= 1'b1;
                    state_q <= PREP;
                end
                PREP: begin
                    r_q    <= '0;
                    cnt_q  <= CW'(WIDTH - 1);
                    zero_q <= (b_q == '0);
                    qneg_q <= sgn_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                    rneg_q <= sgn_q & a_q[WIDTH-1];
                    // Divide-by-zero keeps the raw dividend so it can be returned as the remainder.
                    if (b_q == '0) begin
                        state_q <= FIX;
                    end else begin
                        if (sgn_q && a_q[WIDTH-1]) a_q <= -a_q;
                        if (sgn_q && b_q[WIDTH-1]) b_q <= -b_q;
                        state_q <= ITER;
                    end
                end
                ITER: begin
                    r_q <= r_d;
                    a_q <= {a_q[WIDTH-2:0], qbit};
                    if (cnt_q == '0) state_q <= FIX;
                    else             cnt_q   <= cnt_q - CW'(1);
                end
                FIX: begin
                    if (zero_q) begin
                        quo_q <= '1;
                        rem_q <= a_q;
                        dbz_q <= 1'b1;
                    end else begin
                        quo_q <= qneg_q ? -a_q : a_q;
                        rem_q <= rneg_q ? -r_q : r_q;
                        dbz_q <= 1'b0;
                    end
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quo_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider.sv
// Directed table-driven bench for seq_divider (32-bit signed-capable and 8-bit unsigned-only).
module tb_seq_divider;

    logic clock;
    logic reset_n;
    int   n_tests;
    int   n_fail;

    seq_divider_if #(.WIDTH(32)) bus  ();
    seq_divider_if #(.WIDTH(8))  bus8 ();

    seq_divider #(.WIDTH(32), .SIGNED_EN(1'b1)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    seq_divider #(.WIDTH(8), .SIGNED_EN(1'b0)) dut8 (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus8.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic        sg;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
        int          lat;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Launch one 32-bit operation and wait for done; lat counts edges after the start edge.
    task automatic do_op(input logic sg, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output bit busy_ok);
        @(negedge clock);
        bus.start     = 1'b1;
        bus.is_signed = sg;
        bus.dividend  = a;
        bus.divisor   = b;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        lat       = 0;
        busy_ok   = 1'b1;
        while (!bus.done && lat < 100) begin
            if (!bus.busy) busy_ok = 1'b0;
            @(posedge clock);
            #1;
            lat++;
        end
    endtask

    initial begin
        int lat;
        int done_seen;
        bit busy_ok;

        n_tests = 0;
        n_fail  = 0;

        vecs[0] = '{"u100/7",     1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 34};
        vecs[1] = '{"s-7/2",      1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0, 34};
        vecs[2] = '{"u-7/2",      1'b0, 32'hFFFFFFF9,   32'd2,          32'h7FFFFFFC,   32'd1,          1'b0, 34};
        vecs[3] = '{"u5/0",       1'b0, 32'd5,          32'd0,          32'hFFFFFFFF,   32'd5,          1'b1, 2};
        vecs[4] = '{"u10/3",      1'b0, 32'd10,         32'd3,          32'd3,          32'd1,          1'b0, 34};
        vecs[5] = '{"sMIN/-1",    1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0, 34};
        vecs[6] = '{"s7/-2",      1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          1'b0, 34};
        vecs[7] = '{"s-7/0",      1'b1, 32'hFFFFFFF9,   32'd0,          32'hFFFFFFFF,   32'hFFFFFFF9,   1'b1, 2};
        vecs[8] = '{"uMAX/1",     1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          1'b0, 34};
        vecs[9] = '{"u3/10",      1'b0, 32'd3,          32'd10,         32'd0,          32'd3,          1'b0, 34};

        reset_n        = 1'b0;
        bus.start      = 1'b0;
        bus.is_signed  = 1'b0;
        bus.dividend   = '0;
        bus.divisor    = '0;
        bus8.start     = 1'b0;
        bus8.is_signed = 1'b0;
        bus8.dividend  = '0;
        bus8.divisor   = '0;

        repeat (2) @(posedge clock);
        #1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_q",    bus.quotient,  32'd0);
        chk("rst_r",    bus.remainder, 32'd0);
        chk("rst_dbz",  32'(bus.div_by_zero), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i].sg, vecs[i].a, vecs[i].b, lat, busy_ok);
            chk({vecs[i].name, "_lat"},  32'(lat), 32'(vecs[i].lat));
            chk({vecs[i].name, "_busy"}, 32'(busy_ok), 32'd1);
            chk({vecs[i].name, "_q"},    bus.quotient,  vecs[i].q);
            chk({vecs[i].name, "_r"},    bus.remainder, vecs[i].r);
            chk({vecs[i].name, "_dbz"},  32'(bus.div_by_zero), 32'(vecs[i].dbz));
            chk({vecs[i].name, "_busy_at_done"}, 32'(bus.busy), 32'd0);
        end

        // start pulsed with different operands mid-ITER must be ignored
        @(negedge clock);
        bus.start = 1'b1; bus.is_signed = 1'b0; bus.dividend = 32'd100; bus.divisor = 32'd7;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        lat = 0;
        while (!bus.done && lat < 100) begin
            if (lat == 10) begin
                bus.start = 1'b1; bus.dividend = 32'd50; bus.divisor = 32'd5;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clock);
            #1;
            lat++;
        end
        bus.start = 1'b0;
        chk("midstart_lat", 32'(lat), 32'd34);
        chk("midstart_q",   bus.quotient,  32'd14);
        chk("midstart_r",   bus.remainder, 32'd2);

        // back-to-back: second start lands in the done cycle of the first
        do_op(1'b0, 32'd200, 32'd7, lat, busy_ok);
        chk("b2b_first_q", bus.quotient, 32'd28);
        do_op(1'b0, 32'd1000, 32'd9, lat, busy_ok);
        chk("b2b_lat", 32'(lat), 32'd34);
        chk("b2b_q",   bus.quotient,  32'd111);
        chk("b2b_r",   bus.remainder, 32'd1);

        // asynchronous reset mid-ITER discards the operation
        @(negedge clock);
        bus.start = 1'b1; bus.dividend = 32'd100; bus.divisor = 32'd7;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_busy", 32'(bus.busy), 32'd0);
        chk("arst_q",    bus.quotient,  32'd0);
        chk("arst_r",    bus.remainder, 32'd0);
        chk("arst_dbz",  32'(bus.div_by_zero), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        done_seen = 0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (bus.done || bus.busy) done_seen++;
        end
        chk("arst_no_done", 32'(done_seen), 32'd0);

        // 8-bit instance with signed support disabled: is_signed is ignored
        @(negedge clock);
        bus8.start = 1'b1; bus8.is_signed = 1'b1; bus8.dividend = 8'd200; bus8.divisor = 8'd3;
        @(posedge clock);
        #1;
        bus8.start = 1'b0;
        lat = 0;
        while (!bus8.done && lat < 100) begin
            @(posedge clock);
            #1;
            lat++;
        end
        chk("w8_lat", 32'(lat), 32'd10);
        chk("w8_q",   32'(bus8.quotient),  32'd66);
        chk("w8_r",   32'(bus8.remainder), 32'd2);
        chk("w8_dbz", 32'(bus8.div_by_zero), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
